// File: rtl/mem_writeback.sv
// Memory/writeback stage: ALU results retire in one cycle; loads and stores go through a
// valid/ready data-memory request, with misalignment detection and an optional load-response timeout.
module mem_writeback #(
  parameter int LOAD_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_addr,
  input  logic [4:0]  in_dest,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [63:0] dmem_req_addr,
  output logic        dmem_req_we,
  output logic [63:0] dmem_req_wdata,
  output logic [7:0]  dmem_req_strb,
  input  logic        dmem_resp_valid,
  input  logic [63:0] dmem_resp_data,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [63:0] wb_data,
  output logic        err_misaligned,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam int CW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    ld_off;
  logic [2:0]    ld_funct3;
  logic [4:0]    ld_dest;

  logic [3:0]    size_b;
  logic [7:0]    size_mask;
  logic          misaligned;
  logic [63:0]   resp_shift;
  logic [63:0]   load_val;

  assign in_ready = (state == IDLE);

  always_comb begin
    size_b    = 4'd1;
    size_mask = 8'h01;
    case (in_funct3[1:0])
      2'd0: begin size_b = 4'd1; size_mask = 8'h01; end
      2'd1: begin size_b = 4'd2; size_mask = 8'h03; end
      2'd2: begin size_b = 4'd4; size_mask = 8'h0F; end
      default: begin size_b = 4'd8; size_mask = 8'hFF; end
    endcase
    misaligned = ({1'b0, in_addr[2:0]} + size_b) > 4'd8;
  end

  // Response lane extraction uses the latched offset/funct3, not the live inputs.
  always_comb begin
    resp_shift = dmem_resp_data >> {ld_off, 3'b000};
    load_val   = resp_shift;
    case (ld_funct3[1:0])
      2'd0: load_val = ld_funct3[2] ? {56'd0, resp_shift[7:0]}
                                    : {{56{resp_shift[7]}}, resp_shift[7:0]};
      2'd1: load_val = ld_funct3[2] ? {48'd0, resp_shift[15:0]}
                                    : {{48{resp_shift[15]}}, resp_shift[15:0]};
      2'd2: load_val = ld_funct3[2] ? {32'd0, resp_shift[31:0]}
                                    : {{32{resp_shift[31]}}, resp_shift[31:0]};
      default: load_val = resp_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      ld_off         <= '0;
      ld_funct3      <= '0;
      ld_dest        <= '0;
      dmem_req_valid <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_we    <= 1'b0;
      dmem_req_wdata <= '0;
      dmem_req_strb  <= '0;
      wb_en          <= 1'b0;
      wb_reg         <= '0;
      wb_data        <= '0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      wb_en          <= 1'b0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!in_load && !in_store) begin
              wb_en   <= (in_dest != 5'd0);
              wb_reg  <= in_dest;
              wb_data <= in_data;
            end else if (misaligned) begin
              err_misaligned <= 1'b1;
            end else begin
              // Store wins when both flags are set.
              dmem_req_valid <= 1'b1;
              dmem_req_addr  <= {in_addr[63:3], 3'b000};
              dmem_req_we    <= in_store;
              dmem_req_wdata <= in_store ? (in_data << {in_addr[2:0], 3'b000}) : 64'd0;
              dmem_req_strb  <= in_store ? (size_mask << in_addr[2:0]) : 8'd0;
              ld_off         <= in_addr[2:0];
              ld_funct3      <= in_funct3;
              ld_dest        <= in_dest;
              state          <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            wait_cnt       <= '0;
            state          <= dmem_req_we ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (dmem_resp_valid) begin
            wb_en   <= (ld_dest != 5'd0);
            wb_reg  <= ld_dest;
            wb_data <= load_val;
            state   <= IDLE;
          end else if (LOAD_TIMEOUT != 0 && wait_cnt == CW'(LOAD_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
